// File: rtl/dcache_tag_ctrl_pkg.sv
// Shared definitions for the D-cache tag sequencer: controller states, line-address
// width and the tag-width helper used by the interface and the controller.
package dcache_tag_ctrl_pkg;

  localparam int unsigned LADR_W      = 23;
  localparam int unsigned DRWIDTH_DEF = 12;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_MISS   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

  // Tag field width for a given index width (line address minus index bits).
  function automatic int unsigned tag_w(input int unsigned drwidth);
    return LADR_W - drwidth;
  endfunction

endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// Bundle of the tag sequencer's external handshakes:
//  - lookup request/response with the MA-stage front end (req_*, resp_*)
//  - refill handshake with the memory refill engine (refill_*)
//  - invalidate-all request/busy (flush_*)
//  - tag RAM read/write port (tag_*), RAM registers tag_radr, tag_rdata follows 1 cycle later
// Modport slave is the controller's view, master is the surrounding environment's.
interface dcache_tag_ctrl_if #(
  parameter int unsigned DRWIDTH = dcache_tag_ctrl_pkg::DRWIDTH_DEF
);

  localparam int unsigned LADR_W = dcache_tag_ctrl_pkg::LADR_W;
  localparam int unsigned ENT_W  = dcache_tag_ctrl_pkg::tag_w(DRWIDTH) + 1;

  logic                req_valid;
  logic [LADR_W-1:0]   req_ladr;
  logic                req_ready;
  logic                resp_valid;
  logic                resp_hit;
  logic                refill_req;
  logic [LADR_W-1:0]   refill_ladr;
  logic                refill_done;
  logic                flush_req;
  logic                flush_busy;
  logic [DRWIDTH-1:0]  tag_radr;
  logic [ENT_W-1:0]    tag_rdata;
  logic [DRWIDTH-1:0]  tag_wadr;
  logic [ENT_W-1:0]    tag_wdata;
  logic                tag_wen;

  modport slave (
    input  req_valid, req_ladr, refill_done, flush_req, tag_rdata,
    output req_ready, resp_valid, resp_hit, refill_req, refill_ladr,
           flush_busy, tag_radr, tag_wadr, tag_wdata, tag_wen
  );

  modport master (
    output req_valid, req_ladr, refill_done, flush_req, tag_rdata,
    input  req_ready, resp_valid, resp_hit, refill_req, refill_ladr,
           flush_busy, tag_radr, tag_wadr, tag_wdata, tag_wen
  );

endinterface

// File: rtl/dcache_tag_ctrl.sv
// Sequencer for the direct-mapped D-cache tag RAM. Clears every tag after reset,
// performs hit/miss lookups, requests a refill on miss, writes {valid,tag} once the
// refill completes and runs invalidate-all sweeps on flush requests.
// Ports:
//  clk  - clock
//  rst  - synchronous reset, active-high
//  bus  - dcache_tag_ctrl_if.slave: lookup, refill, flush and tag RAM port signals
// All outputs are registers except req_ready (blocked in the cycle a new flush arrives,
// since flush wins over a lookup) and tag_radr (follows req_ladr so the RAM can register
// the index in the accept cycle). A lookup response appears the cycle after LOOKUP.
module dcache_tag_ctrl
  import dcache_tag_ctrl_pkg::*;
#(
  parameter int unsigned DRWIDTH = DRWIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dcache_tag_ctrl_if.slave bus
);

  localparam int unsigned       TAG_W   = tag_w(DRWIDTH);
  localparam int unsigned       ENT_W   = TAG_W + 1;
  localparam logic [DRWIDTH-1:0] CNT_MAX = '1;

  state_t              r_state;
  logic [DRWIDTH-1:0]  r_cnt;
  logic [LADR_W-1:0]   r_ladr;
  logic                r_flush_pend;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic                r_refill_req;
  logic [LADR_W-1:0]   r_refill_ladr;
  logic                r_flush_busy;
  logic                r_tag_wen;
  logic [DRWIDTH-1:0]  r_tag_wadr;
  logic [ENT_W-1:0]    r_tag_wdata;

  logic                w_flush_any;
  logic [ENT_W-1:0]    w_tag_expect;
  logic                w_tag_match;

  // A flush is due if one is already pending or arrives this cycle.
  assign w_flush_any  = r_flush_pend | bus.flush_req;
  // Entry the latched line must match to hit; also the value written after refill.
  assign w_tag_expect = {1'b1, r_ladr[LADR_W-1:DRWIDTH]};
  assign w_tag_match  = (bus.tag_rdata == w_tag_expect);

  // Controller FSM with registered outputs, loaded for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_cnt         <= '0;
      r_ladr        <= '0;
      r_flush_pend  <= 1'b0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_refill_req  <= 1'b0;
      r_refill_ladr <= '0;
      r_flush_busy  <= 1'b1;
      r_tag_wen     <= 1'b0;
      r_tag_wadr    <= '0;
      r_tag_wdata   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_tag_wen    <= 1'b0;

      // Flushes seen outside IDLE collapse into one pending sweep.
      if (bus.flush_req && (r_state != ST_IDLE)) begin
        r_flush_pend <= 1'b1;
      end

      case (r_state)
        ST_INIT, ST_FLUSH: begin
          // One entry cleared per cycle; the write for cnt lands the following cycle.
          r_tag_wen   <= 1'b1;
          r_tag_wadr  <= r_cnt;
          r_tag_wdata <= '0;
          r_cnt       <= r_cnt + DRWIDTH'(1);
          if (r_cnt == CNT_MAX) begin
            r_state      <= ST_IDLE;
            r_flush_busy <= 1'b0;
            r_req_ready  <= ~w_flush_any;
          end
        end

        ST_IDLE: begin
          if (w_flush_any) begin
            r_state      <= ST_FLUSH;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_flush_busy <= 1'b1;
            r_req_ready  <= 1'b0;
          end else if (bus.req_valid && r_req_ready) begin
            r_ladr      <= bus.req_ladr;
            r_state     <= ST_LOOKUP;
            r_req_ready <= 1'b0;
          end
        end

        ST_LOOKUP: begin
          if (w_tag_match) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_state      <= ST_IDLE;
            r_req_ready  <= ~w_flush_any;
          end else begin
            r_refill_req  <= 1'b1;
            r_refill_ladr <= r_ladr;
            r_state       <= ST_MISS;
          end
        end

        ST_MISS: begin
          if (bus.refill_done) begin
            r_refill_req <= 1'b0;
            r_tag_wen    <= 1'b1;
            r_tag_wadr   <= r_ladr[DRWIDTH-1:0];
            r_tag_wdata  <= w_tag_expect;
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_state      <= ST_UPDATE;
          end
        end

        ST_UPDATE: begin
          r_state     <= ST_IDLE;
          r_req_ready <= ~w_flush_any;
        end

        default: begin
          r_state      <= ST_INIT;
          r_cnt        <= '0;
          r_flush_busy <= 1'b1;
          r_req_ready  <= 1'b0;
          r_refill_req <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in IDLE takes priority, so it also withdraws the ready.
  assign bus.req_ready   = r_req_ready & ~bus.flush_req;
  assign bus.tag_radr    = bus.req_ladr[DRWIDTH-1:0];
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_hit    = r_resp_hit;
  assign bus.refill_req  = r_refill_req;
  assign bus.refill_ladr = r_refill_ladr;
  assign bus.flush_busy  = r_flush_busy;
  assign bus.tag_wen     = r_tag_wen;
  assign bus.tag_wadr    = r_tag_wadr;
  assign bus.tag_wdata   = r_tag_wdata;

endmodule
